// File: rtl/mem_stream_master.sv
// Burst mover between a valid/ready stream and a single-port register-file memory.
// All outputs are registered or decoded from the state register.
//
// state  | meaning
// IDLE   | waiting for iStart; command latched on accept
// WRITE  | input stream open; each handshake registers one memory write
// WFLUSH | last write strobe on the bus, stream closed
// RREQ   | read strobe on the bus for the current word
// RCAP   | memory data valid; captured into the output register
// ROUT   | output word presented until the consumer takes it
// DONE   | one-cycle completion pulse
module mem_stream_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     iClk,
    input  logic                     iReset_n,
    input  logic                     iStart,
    input  logic                     iDir,
    input  logic [ADDRESS_WIDTH-1:0] iBase,
    input  logic [ADDRESS_WIDTH-1:0] iLength,
    output logic                     oBusy,
    output logic                     oDone,
    input  logic                     iInValid,
    input  logic [DATA_WIDTH-1:0]    iInData,
    output logic                     oInReady,
    output logic                     oOutValid,
    output logic [DATA_WIDTH-1:0]    oOutData,
    input  logic                     iOutReady,
    output logic                     oChipSelect_n,
    output logic                     oRead_n,
    output logic                     oWrite_n,
    output logic [ADDRESS_WIDTH-1:0] oAddress,
    output logic [DATA_WIDTH-1:0]    oWriteData,
    input  logic [DATA_WIDTH-1:0]    iReadData
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WFLUSH, S_RREQ, S_RCAP, S_ROUT, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] base_q, base_d;
    logic [ADDRESS_WIDTH-1:0] len_q, len_d;
    logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
    logic                     cs_n_q, cs_n_d;
    logic                     rd_n_q, rd_n_d;
    logic                     wr_n_q, wr_n_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    odata_q, odata_d;
    logic                     ovalid_q, ovalid_d;

    logic [ADDRESS_WIDTH-1:0] idx_inc;
    logic                     last_word;

    assign idx_inc   = idx_q + ADDRESS_WIDTH'(1);
    assign last_word = (idx_q == len_q);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        // strobes are single-cycle pulses unless re-armed below
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    base_d = iBase;
                    len_d  = iLength;
                    idx_d  = '0;
                    if (iDir) begin
                        state_d = S_RREQ;
                        cs_n_d  = 1'b0;
                        rd_n_d  = 1'b0;
                        addr_d  = iBase;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // oInReady is high for the whole state, so valid alone is the handshake
                if (iInValid) begin
                    cs_n_d  = 1'b0;
                    wr_n_d  = 1'b0;
                    addr_d  = base_q + idx_q;
                    wdata_d = iInData;
                    if (last_word) begin
                        state_d = S_WFLUSH;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            S_WFLUSH: state_d = S_DONE;
            S_RREQ:   state_d = S_RCAP;
            S_RCAP: begin
                odata_d  = iReadData;
                ovalid_d = 1'b1;
                state_d  = S_ROUT;
            end
            S_ROUT: begin
                if (iOutReady) begin
                    ovalid_d = 1'b0;
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = S_RREQ;
                        cs_n_d  = 1'b0;
                        rd_n_d  = 1'b0;
                        addr_d  = base_q + idx_inc;
                    end
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign oChipSelect_n = cs_n_q;
    assign oRead_n       = rd_n_q;
    assign oWrite_n      = wr_n_q;
    assign oAddress      = addr_q;
    assign oWriteData    = wdata_q;
    assign oOutData      = odata_q;
    assign oOutValid     = ovalid_q;
    assign oInReady      = (state_q == S_WRITE);
    assign oDone         = (state_q == S_DONE);
    assign oBusy         = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_mem_stream_master.sv
// Randomized bench for mem_stream_master with an attached register-file memory
// and an array model of what the memory should hold.
module tb_mem_stream_master;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          iClk;
    logic          iReset_n;
    logic          iStart;
    logic          iDir;
    logic [AW-1:0] iBase;
    logic [AW-1:0] iLength;
    logic          oBusy;
    logic          oDone;
    logic          iInValid;
    logic [DW-1:0] iInData;
    logic          oInReady;
    logic          oOutValid;
    logic [DW-1:0] oOutData;
    logic          iOutReady;
    logic          oChipSelect_n;
    logic          oRead_n;
    logic          oWrite_n;
    logic [AW-1:0] oAddress;
    logic [DW-1:0] oWriteData;
    logic [DW-1:0] iReadData;

    logic [DW-1:0] tb_mem  [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int vectors;
    int miscompares;

    mem_stream_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iStart(iStart), .iDir(iDir),
        .iBase(iBase), .iLength(iLength), .oBusy(oBusy), .oDone(oDone),
        .iInValid(iInValid), .iInData(iInData), .oInReady(oInReady),
        .oOutValid(oOutValid), .oOutData(oOutData), .iOutReady(iOutReady),
        .oChipSelect_n(oChipSelect_n), .oRead_n(oRead_n), .oWrite_n(oWrite_n),
        .oAddress(oAddress), .oWriteData(oWriteData), .iReadData(iReadData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // External memory: registered read, data valid the cycle after the strobe
    always @(posedge iClk) begin
        if (!oChipSelect_n && !oWrite_n) tb_mem[oAddress] <= oWriteData;
        if (!oChipSelect_n && !oRead_n)  iReadData <= tb_mem[oAddress];
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        logic [74:0] obs;
        iReset_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            iStart    = 1'($urandom);
            iDir      = 1'($urandom);
            iBase     = AW'($urandom);
            iLength   = AW'($urandom);
            iInValid  = 1'($urandom);
            iInData   = $urandom;
            iOutReady = 1'($urandom);
            tick();
            obs = {oChipSelect_n, oRead_n, oWrite_n, oAddress, oWriteData, oOutData,
                   oOutValid, oInReady, oBusy, oDone};
            vectors++;
            if (obs !== {3'b111, 4'h0, 32'h0, 32'h0, 4'b0000}) begin
                miscompares++;
                $display("FAIL reset_values cycle %0d: got %h expected %h", c, obs,
                         {3'b111, 4'h0, 32'h0, 32'h0, 4'b0000});
            end
        end
        iStart = 1'b0; iInValid = 1'b0; iOutReady = 1'b0;
        iReset_n = 1'b1;
        tick();
        vectors++;
        if ({oBusy, oDone, oChipSelect_n} !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_release: busy/done/cs got %b expected 001", {oBusy, oDone, oChipSelect_n});
        end
    endtask

    task automatic test_write(input logic [AW-1:0] base, input logic [AW-1:0] len,
                              input int gap_pct, input bit rand_data, input logic [DW-1:0] seq);
        logic [DW-1:0] d [DEPTH];
        logic [AW-1:0] a;
        int k;
        int guard;
        bit hs;
        for (int n = 0; n < DEPTH; n++) d[n] = rand_data ? $urandom : seq + DW'(n);
        iDir = 1'b0; iBase = base; iLength = len; iStart = 1'b1;
        tick();
        iStart = 1'b0; iBase = AW'($urandom); iLength = AW'($urandom);
        vectors++;
        if ({oBusy, oInReady, oDone} !== 3'b110) begin
            miscompares++;
            $display("FAIL write_start: busy/inready/done got %b expected 110", {oBusy, oInReady, oDone});
        end
        k = 0;
        guard = 0;
        while (k <= int'(len) && guard < 300) begin
            iInValid = ($urandom_range(99) >= gap_pct);
            iInData  = iInValid ? d[k] : $urandom;
            hs = iInValid && oInReady;
            tick();
            guard++;
            vectors++;
            if (hs) begin
                a = base + AW'(k);
                if ({oChipSelect_n, oWrite_n, oRead_n, oAddress, oWriteData} !== {3'b001, a, d[k]}) begin
                    miscompares++;
                    $display("FAIL write_strobe word %0d: cs/wr/rd/addr/data got %b %h %h expected 001 %h %h",
                             k, {oChipSelect_n, oWrite_n, oRead_n}, oAddress, oWriteData, a, d[k]);
                end
                k++;
            end else if ({oChipSelect_n, oWrite_n, oRead_n} !== 3'b111) begin
                miscompares++;
                $display("FAIL write_gap_strobes: got %b expected 111", {oChipSelect_n, oWrite_n, oRead_n});
            end
        end
        if (guard >= 300) begin
            vectors++; miscompares++;
            $display("FAIL write_timeout: accepted %0d words expected %0d", k, int'(len) + 1);
        end
        iInValid = 1'($urandom);
        iInData  = $urandom;
        vectors++;
        if ({oInReady, oBusy, oDone} !== 3'b010) begin
            miscompares++;
            $display("FAIL wflush: inready/busy/done got %b expected 010", {oInReady, oBusy, oDone});
        end
        tick();
        iInValid = 1'b0;
        vectors++;
        if ({oDone, oBusy, oInReady, oChipSelect_n, oWrite_n} !== 5'b10011) begin
            miscompares++;
            $display("FAIL write_done: done/busy/inready/cs/wr got %b expected 10011",
                     {oDone, oBusy, oInReady, oChipSelect_n, oWrite_n});
        end
        tick();
        vectors++;
        if ({oDone, oBusy} !== 2'b00) begin
            miscompares++;
            $display("FAIL write_idle: done/busy got %b expected 00", {oDone, oBusy});
        end
        for (int n = 0; n <= int'(len); n++) ref_mem[AW'(int'(base) + n)] = d[n];
        for (int n = 0; n < DEPTH; n++) begin
            vectors++;
            if (tb_mem[n] !== ref_mem[n]) begin
                miscompares++;
                $display("FAIL write_mem addr %0d: got %h expected %h", n, tb_mem[n], ref_mem[n]);
            end
        end
    endtask

    task automatic test_read(input logic [AW-1:0] base, input logic [AW-1:0] len,
                             input int hold, input bit pulse_start);
        int i, cyc, held, rreq, guard;
        bit first, consumed;
        logic [AW-1:0] a;
        iDir = 1'b1; iBase = base; iLength = len; iStart = 1'b1;
        iOutReady = (hold == 0);
        tick();
        iStart = 1'b0;
        cyc = 1; i = 0; held = 0; rreq = 0; guard = 0; first = 1'b1;
        while (i <= int'(len) && guard < 600) begin
            a = base + AW'(i);
            if (!oChipSelect_n && !oRead_n) begin
                rreq++;
                vectors++;
                if (oAddress !== a) begin
                    miscompares++;
                    $display("FAIL read_addr word %0d: got %h expected %h", i, oAddress, a);
                end
            end
            vectors++;
            if ({oWrite_n, oInReady, oBusy, oDone} !== 4'b1010) begin
                miscompares++;
                $display("FAIL read_side: wr/inready/busy/done got %b expected 1010",
                         {oWrite_n, oInReady, oBusy, oDone});
            end
            consumed = 1'b0;
            if (oOutValid) begin
                if (first && hold == 0) begin
                    vectors++;
                    if (cyc != 3 + 3 * i) begin
                        miscompares++;
                        $display("FAIL read_timing word %0d: valid in cycle %0d expected %0d", i, cyc, 3 + 3 * i);
                    end
                end
                first = 1'b0;
                vectors++;
                if (oOutData !== ref_mem[a]) begin
                    miscompares++;
                    $display("FAIL read_data word %0d: got %h expected %h", i, oOutData, ref_mem[a]);
                end
                iOutReady = (held >= hold);
                consumed  = iOutReady;
                if (!iOutReady) held++;
            end else begin
                iOutReady = (hold == 0) ? 1'b1 : 1'($urandom);
            end
            iStart = pulse_start ? 1'($urandom) : 1'b0;
            iDir   = 1'($urandom);
            iBase  = AW'($urandom);
            tick();
            cyc++; guard++;
            if (consumed) begin
                vectors++;
                if (oOutValid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL read_release word %0d: valid got %b expected 0", i, oOutValid);
                end
                i++; held = 0; first = 1'b1;
            end
        end
        iStart = 1'b0;
        if (guard >= 600) begin
            vectors++; miscompares++;
            $display("FAIL read_timeout: delivered %0d words expected %0d", i, int'(len) + 1);
        end
        vectors++;
        if ({oDone, oBusy, oOutValid, oChipSelect_n} !== 4'b1001) begin
            miscompares++;
            $display("FAIL read_done: done/busy/valid/cs got %b expected 1001",
                     {oDone, oBusy, oOutValid, oChipSelect_n});
        end
        vectors++;
        if (rreq != int'(len) + 1) begin
            miscompares++;
            $display("FAIL read_request_count: got %0d expected %0d", rreq, int'(len) + 1);
        end
        tick();
        vectors++;
        if ({oDone, oBusy} !== 2'b00) begin
            miscompares++;
            $display("FAIL read_idle: done/busy got %b expected 00", {oDone, oBusy});
        end
    endtask

    task automatic test_reset_mid_write();
        logic [DW-1:0] d [4];
        logic [AW-1:0] base;
        logic [74:0] obs;
        base = AW'($urandom);
        for (int n = 0; n < 4; n++) d[n] = $urandom;
        iDir = 1'b0; iBase = base; iLength = 4'd10; iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int n = 0; n < 4; n++) begin
            iInValid = 1'b1;
            iInData  = d[n];
            tick();
        end
        // word 3 is on the bus now; reset lands before the memory can take it
        #2;
        iReset_n = 1'b0;
        #1;
        obs = {oChipSelect_n, oRead_n, oWrite_n, oAddress, oWriteData, oOutData,
               oOutValid, oInReady, oBusy, oDone};
        vectors++;
        if (obs !== {3'b111, 4'h0, 32'h0, 32'h0, 4'b0000}) begin
            miscompares++;
            $display("FAIL midburst_reset: got %h expected %h", obs, {3'b111, 4'h0, 32'h0, 32'h0, 4'b0000});
        end
        iInValid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if ({oDone, oBusy} !== 2'b00) begin
                miscompares++;
                $display("FAIL midburst_no_done: done/busy got %b expected 00", {oDone, oBusy});
            end
        end
        iReset_n = 1'b1;
        tick();
        for (int n = 0; n < 3; n++) ref_mem[base + AW'(n)] = d[n];
        for (int n = 0; n < DEPTH; n++) begin
            vectors++;
            if (tb_mem[n] !== ref_mem[n]) begin
                miscompares++;
                $display("FAIL midburst_mem addr %0d: got %h expected %h", n, tb_mem[n], ref_mem[n]);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        iReset_n = 1'b0; iStart = 1'b0; iDir = 1'b0; iBase = '0; iLength = '0;
        iInValid = 1'b0; iInData = '0; iOutReady = 1'b0;

        test_reset();
        test_write(AW'($urandom), 4'd15, 0, 1'b1, 32'h0);
        test_read(AW'($urandom), 4'd15, 0, 1'b0);
        test_write(4'd2, 4'd3, 0, 1'b0, 32'hA0);
        test_write(4'd14, 4'd3, 40, 1'b0, 32'hA0);
        test_read(4'd14, 4'd3, 0, 1'b0);
        test_read(4'd14, 4'd3, 5, 1'b1);
        test_reset_mid_write();
        test_write(AW'($urandom), AW'($urandom), 0, 1'b1, 32'h0);
        for (int r = 0; r < 6; r++) begin
            test_write(AW'($urandom), AW'($urandom), int'($urandom_range(60)), 1'b1, 32'h0);
            test_read(AW'($urandom), AW'($urandom), int'($urandom_range(3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
